// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int unsigned SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle between a requesting FSM (master) and the controller (slave).
interface serial_subtractor_ctrl_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );

endinterface

// File: rtl/serial_subtractor_ctrl_full_subtractor_bit.sv
// One-bit full subtractor built from two cascaded half-subtractor stages.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic borrow1;
    logic borrow2;

    always_comb begin
        d1      = a ^ b;
        borrow1 = ~a & b;
        d       = d1 ^ bin;
        borrow2 = ~d1 & bin;
        bout    = borrow1 | borrow2;
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell sequenced LSB-first
// over WIDTH cycles, framed by a start/busy/done handshake.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
    input logic                      clk,
    input logic                      rst_n,
    serial_subtractor_ctrl_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_r;
    logic             borrow;
    logic             borrow_out_r;
    logic             busy_r;
    logic             done_r;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:  if (bus.start) next = ST_SHIFT;
            ST_SHIFT: if (last_bit) next = ST_DONE;
            ST_DONE:  next = ST_IDLE;
            default:  next = ST_IDLE;
        endcase
    end

    // Handshake outputs are flopped from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next == ST_SHIFT);
            done_r <= (next == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            a_sr         <= '0;
            b_sr         <= '0;
            diff_r       <= '0;
            borrow       <= 1'b0;
            borrow_out_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr         <= bus.a;
                        b_sr         <= bus.b;
                        cnt          <= '0;
                        diff_r       <= '0;
                        borrow       <= 1'b0;
                        borrow_out_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_r <= {cell_d, diff_r[WIDTH-1:1]};
                    borrow <= cell_bout;
                    // borrow_out only moves on the final bit, so it never shows a partial borrow.
                    if (last_bit) begin
                        borrow_out_r <= cell_bout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench: the driver queues expected results, an independent monitor checks each done.
module tb_serial_subtractor_ctrl;
    import serial_sub_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t e;
    int   done_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   busy_run = 0;

    always @(posedge clk) cycle++;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        r.diff = x - y;
        r.bo   = (x < y);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation after exactly W busy cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                done_cyc.push_back(cycle);
                check("busy_len", busy_run, W);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual diff=%0h required no done", bus.diff);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", 32'(bus.diff), 32'(e.diff));
                    check("borrow_out", 32'(bus.borrow_out), 32'(e.bo));
                end
                busy_run = 0;
            end else if (bus.busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end else begin
            busy_run = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual busy=%0b done=%0b required idle", bus.busy, bus.done);
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [W-1:0] x;
        logic [W-1:0] y;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_diff", 32'(bus.diff), 0);
        check("rst_borrow", 32'(bus.borrow_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd200, 8'd55);
        do_op(8'd5, 8'd10);
        do_op(8'h00, 8'hFF);
        do_op(8'hAA, 8'hAA);
        do_op(8'hFF, 8'h00);
        drain();

        // Request during bit 4 must be dropped, not queued.
        do_op(8'd9, 8'd3);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("ignored_no_busy", 32'(bus.busy), 0);

        // Reset while busy at bit 3 aborts the operation.
        do_op(8'h37, 8'h12);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_diff", 32'(bus.diff), 0);
        check("abort_borrow", 32'(bus.borrow_out), 0);
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(bus.busy), 0);
        do_op(8'd100, 8'd1);
        drain();

        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom));
        end
        drain();

        // Start held high: accepts every W+2 cycles; operands change right after each accept.
        wait_idle();
        base = done_cyc.size();
        for (int k = 0; k < 3; k++) begin
            x = W'($urandom);
            y = W'($urandom);
            bus.a     = x;
            bus.b     = y;
            bus.start = 1'b1;
            exp_q.push_back(model(x, y));
            @(negedge clk);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            if (k == 2) bus.start = 1'b0;
            repeat (W + 1) @(negedge clk);
        end
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("b2b_count", done_cyc.size() - base, 3);
        if (done_cyc.size() >= base + 3) begin
            check("b2b_period1", done_cyc[base+1] - done_cyc[base], W + 2);
            check("b2b_period2", done_cyc[base+2] - done_cyc[base+1], W + 2);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial unsigned subtractor controller. It computes `a - b` by sequencing one full-subtractor cell (two half-subtractor stages plus a borrow flip-flop) LSB-first over `WIDTH` cycles. A start/busy/done handshake frames each operation. It sits between a requesting FSM and the subtractor datapath, and trades area for latency.

## Interface

Parameters:
- `WIDTH`, 8: operand and result width in bits; legal values are 2 to 32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request; honoured only in IDLE.
- `a`, input, `WIDTH`: minuend; sampled on the accepting edge only.
- `b`, input, `WIDTH`: subtrahend; sampled on the accepting edge only.
- `busy`, output, 1: high while an operation is in progress (SHIFT state).
- `done`, output, 1: single-cycle pulse; result valid.
- `diff`, output, `WIDTH`: difference `(a - b) mod 2^WIDTH`.
- `borrow_out`, output, 1: final borrow; 1 exactly when `a < b` (unsigned).

## Operation

- States:
  - IDLE: waits for `start`.
  - SHIFT: processes one bit per cycle.
  - DONE: one-cycle result strobe.
- IDLE → SHIFT when `start`=1:
  - latch `a` and `b` into the operand shift registers;
  - clear the borrow flop and the bit counter;
  - `busy`←1.
- In SHIFT, each cycle:
  - bit-cell inputs are `a_sr[0]`, `b_sr[0]` and the borrow flop;
  - cell outputs are `d = a ^ b ^ bin` and `bout = (~a & b) | (~(a ^ b) & bin)`;
  - `d` shifts into the result register from the MSB end; the operand registers shift right;
  - the borrow flop takes `bout`; the counter increments.
- SHIFT → DONE when the counter reaches `WIDTH-1` (after the last bit is processed):
  - `busy`←0, `done`←1;
  - `diff` and `borrow_out` are final.
- DONE → IDLE unconditionally: `done`←0.
- `diff` and `borrow_out` hold their last values until the next accepted `start`. They are cleared at the accepting edge.
- `start` in SHIFT or DONE is ignored; requests are not queued. The requester must re-assert `start` in IDLE.
- Operand changes after the accepting edge have no effect.
- The counter width is `$clog2(WIDTH)`. There is no wrap beyond `WIDTH-1`.

## Timing

- Reset (`rst_n`=0 at an edge):
  - state←IDLE;
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0;
  - counter, shift registers and borrow flop all cleared.
- Reset during SHIFT or DONE aborts the operation; no `done` is produced. Reset overrides `start` on the same edge.
- Latency, with the accepting edge as edge 0:
  - `busy`=1 after edges 0 to `WIDTH-1`;
  - `done`=1 after edge `WIDTH`, for exactly one cycle;
  - the controller is back in IDLE after edge `WIDTH+1`.
- Throughput: one operation per `WIDTH+2` cycles with `start` held high. There is exactly one IDLE cycle between `done` and the next `busy`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `serial_sub_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SHIFT`, `ST_DONE` (2-bit);
  - default width constant `SUB_WIDTH_DEF` = 8.
- One combinational sub-module, `full_subtractor_bit`:
  - ports `a`, `b`, `bin`, `d`, `bout`;
  - built from two half-subtractor stages with `bout = borrow1 | borrow2`.
- The top level holds the FSM, counter, operand and result shift registers, and the borrow flop.

## Test plan

- Nominal: `WIDTH`=8, `a`=200, `b`=55, pulse `start` → `busy` for 8 cycles, then `done` pulse; `diff`=145, `borrow_out`=0.
- Underflow: `a`=5, `b`=10 → `diff`=251 (0xFB), `borrow_out`=1. Also `a`=0x00, `b`=0xFF → `diff`=0x01, `borrow_out`=1.
- Equal and edge operands:
  - `a`=`b`=0xAA → `diff`=0, `borrow_out`=0;
  - `a`=0xFF, `b`=0x00 → `diff`=0xFF, `borrow_out`=0.
- Ignored request: pulse `start` with `a`=9, `b`=3. During bit 4 assert `start` with `a`=1, `b`=2 → single `done`, `diff`=6. No second operation begins without a new `start` in IDLE.
- Reset mid-operation: `rst_n`=0 for one edge while `busy` at bit 3 → next cycle `busy`=0, `done`=0, `diff`=0, `borrow_out`=0; no `done` afterwards. A new `start` works normally.
- Back-to-back: `start` held high for 3 operations → `done` at cycles 8, 18 and 28 (period 10 = `WIDTH+2`). Each `diff` matches the operands present at its accepting edge.
